ahb_lite_manager: RTL and testbench

- Single-outstanding AHB-Lite manager (initiator) that drives the AHB subordinate register block from a simple command/response interface.
- Used by the bench-side and host-side logic to issue reads and writes to the USB endpoint register and data-buffer window (4-bit address space, 32-bit data).
- Converts one accepted command into one NONSEQ transfer, handles wait states and the two-cycle ERROR response, and returns read data or error status.

---
 rtl/ahb_lite_manager.sv | 232 +++++++++++++++++++++++
 tb/tb_ahb_lite_manager.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_manager.sv
// Single-outstanding AHB-Lite manager: one command becomes one NONSEQ transfer.
// Optional wait-state watchdog enabled by defining AHB_MGR_TIMEOUT_EN.
module ahb_lite_manager #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              rsp_timeout,
    output logic              hsel,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        hsize,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Size 3 is undefined here; half/word accesses must be naturally aligned.
    function automatic logic cmd_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'd0:    cmd_illegal = 1'b0;
            2'd1:    cmd_illegal = addr_lo[0];
            2'd2:    cmd_illegal = (addr_lo != 2'b00);
            default: cmd_illegal = 1'b1;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                hsel_q, hsel_d;
    logic [ADDR_W-1:0]   haddr_q, haddr_d;
    logic [1:0]          hsize_q, hsize_d;
    logic [1:0]          htrans_q, htrans_d;
    logic                hwrite_q, hwrite_d;
    logic [DATA_W-1:0]   hwdata_q, hwdata_d;
    logic [DATA_W-1:0]   wdata_hold_q, wdata_hold_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_error_q, rsp_error_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_timeout_d;

`ifdef AHB_MGR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_timeout_q;
`else
    logic [31:0]      timeout_cfg_unused;
    assign timeout_cfg_unused = TIMEOUT_CYCLES;
`endif

    // Next-state and registered-output computation for the transfer FSM.
    always_comb begin
        state_d       = state_q;
        hsel_d        = hsel_q;
        haddr_d       = haddr_q;
        hsize_d       = hsize_q;
        htrans_d      = htrans_q;
        hwrite_d      = hwrite_q;
        hwdata_d      = hwdata_q;
        wdata_hold_d  = wdata_hold_q;
        rsp_valid_d   = 1'b0;
        rsp_error_d   = 1'b0;
        rsp_rdata_d   = {DATA_W{1'b0}};
        rsp_timeout_d = 1'b0;
`ifdef AHB_MGR_TIMEOUT_EN
        tmo_cnt_d     = {CNT_W{1'b0}};
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_illegal(cmd_size, cmd_addr[1:0])) begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end else begin
                        haddr_d      = cmd_addr;
                        hsize_d      = cmd_size;
                        hwrite_d     = cmd_write;
                        hsel_d       = 1'b1;
                        htrans_d     = HTRANS_NONSEQ;
                        wdata_hold_d = cmd_wdata;
                        state_d      = ST_ADDR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (hready) begin
                    htrans_d = HTRANS_IDLE;
                    hsel_d   = 1'b0;
                    hwdata_d = hwrite_q ? wdata_hold_q : {DATA_W{1'b0}};
                    state_d  = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (hresp) begin
                    // hresp with hready high skips the first error cycle; still an error.
                    if (hready) begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else if (hready) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = hwrite_q ? {DATA_W{1'b0}} : hrdata;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_ERR: begin
                if (hready) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                htrans_d = HTRANS_IDLE;
                hsel_d   = 1'b0;
            end
        endcase
`ifdef AHB_MGR_TIMEOUT_EN
        if ((state_q != ST_IDLE) && !hready) begin
            if (tmo_cnt_q == TMO_LAST) begin
                state_d       = ST_IDLE;
                htrans_d      = HTRANS_IDLE;
                hsel_d        = 1'b0;
                rsp_valid_d   = 1'b1;
                rsp_error_d   = 1'b1;
                rsp_timeout_d = 1'b1;
                rsp_rdata_d   = {DATA_W{1'b0}};
                tmo_cnt_d     = {CNT_W{1'b0}};
            end else begin
                tmo_cnt_d = tmo_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            tmo_cnt_d = {CNT_W{1'b0}};
        end
`endif
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b1;
            hsel_q        <= 1'b0;
            haddr_q       <= {ADDR_W{1'b0}};
            hsize_q       <= 2'b00;
            htrans_q      <= HTRANS_IDLE;
            hwrite_q      <= 1'b0;
            hwdata_q      <= {DATA_W{1'b0}};
            wdata_hold_q  <= {DATA_W{1'b0}};
            rsp_valid_q   <= 1'b0;
            rsp_error_q   <= 1'b0;
            rsp_rdata_q   <= {DATA_W{1'b0}};
`ifdef AHB_MGR_TIMEOUT_EN
            tmo_cnt_q     <= {CNT_W{1'b0}};
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            hsel_q        <= hsel_d;
            haddr_q       <= haddr_d;
            hsize_q       <= hsize_d;
            htrans_q      <= htrans_d;
            hwrite_q      <= hwrite_d;
            hwdata_q      <= hwdata_d;
            wdata_hold_q  <= wdata_hold_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_error_q   <= rsp_error_d;
            rsp_rdata_q   <= rsp_rdata_d;
`ifdef AHB_MGR_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign hsel      = hsel_q;
    assign haddr     = haddr_q;
    assign hsize     = hsize_q;
    assign htrans    = htrans_q;
    assign hwrite    = hwrite_q;
    assign hwdata    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef AHB_MGR_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
    logic rsp_timeout_d_unused;
    assign rsp_timeout_d_unused = rsp_timeout_d;
`endif

endmodule

// File: tb/tb_ahb_lite_manager.sv
// Directed bench for ahb_lite_manager; the subordinate side is driven step by step.
module tb_ahb_lite_manager;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [3:0]  cmd_addr = 4'h0;
    logic [1:0]  cmd_size = 2'd0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        hsel;
    logic [3:0]  haddr;
    logic [1:0]  hsize;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] hrdata = 32'h0;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;

    int checks = 0;
    int passes = 0;

    ahb_lite_manager #(.ADDR_W(4), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout),
        .hsel(hsel), .haddr(haddr), .hsize(hsize), .htrans(htrans),
        .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic issue(input logic wr, input logic [3:0] a, input logic [1:0] sz, input logic [31:0] wd);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_size  = sz;
        cmd_wdata = wd;
    endtask

    initial begin
        logic [3:0]  a_exp;
        logic [31:0] wd_exp;

        // Reset state while rst is high.
        tick();
        tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_htrans", htrans, 2'b00);
        check("rst_hsel", hsel, 0);
        check("rst_haddr", haddr, 0);
        check("rst_hwdata", hwdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        rst = 1'b0;
        tick();

        // Word write, no wait states.
        issue(1'b1, 4'h0, 2'd2, 32'hDEADBEEF);
        tick();
        cmd_valid = 1'b0;
        check("wr_htrans_nonseq", htrans, 2'b10);
        check("wr_hsel", hsel, 1);
        check("wr_hwrite", hwrite, 1);
        check("wr_hsize", hsize, 2'd2);
        check("wr_cmd_ready_busy", cmd_ready, 0);
        tick();
        check("wr_htrans_idle", htrans, 2'b00);
        check("wr_hwdata", hwdata, 32'hDEADBEEF);
        check("wr_rsp_early", rsp_valid, 0);
        tick();
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_error", rsp_error, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        tick();
        check("wr_rsp_single", rsp_valid, 0);

        // Half read with two wait states in the data phase.
        issue(1'b0, 4'h2, 2'd1, 32'h0);
        tick();
        cmd_valid = 1'b0;
        check("rdh_haddr", haddr, 4'h2);
        check("rdh_hwrite", hwrite, 0);
        tick();
        hready = 1'b0;
        check("rdh_hwdata_zero", hwdata, 0);
        tick();
        check("rdh_wait1", rsp_valid, 0);
        tick();
        hready = 1'b1;
        hrdata = 32'h0000A5A5;
        check("rdh_wait2", rsp_valid, 0);
        tick();
        check("rdh_rsp_valid", rsp_valid, 1);
        check("rdh_rsp_rdata", rsp_rdata, 32'h0000A5A5);
        check("rdh_rsp_error", rsp_error, 0);
        hrdata = 32'h0;

        // Two-cycle ERROR response on a word read.
        tick();
        issue(1'b0, 4'h8, 2'd2, 32'h0);
        tick();
        cmd_valid = 1'b0;
        check("err_htrans_nonseq", htrans, 2'b10);
        tick();
        hresp  = 1'b1;
        hready = 1'b0;
        hrdata = 32'h12345678;
        check("err_htrans_idle1", htrans, 2'b00);
        tick();
        hready = 1'b1;
        check("err_htrans_idle2", htrans, 2'b00);
        check("err_no_rsp_yet", rsp_valid, 0);
        tick();
        hresp  = 1'b0;
        hrdata = 32'h0;
        check("err_rsp_valid", rsp_valid, 1);
        check("err_rsp_error", rsp_error, 1);
        check("err_rsp_rdata", rsp_rdata, 0);
        check("err_htrans_idle3", htrans, 2'b00);

        // Local rejects: misaligned word, then size 3.
        tick();
        issue(1'b1, 4'h3, 2'd2, 32'h55555555);
        tick();
        cmd_valid = 1'b0;
        check("mis_rsp_valid", rsp_valid, 1);
        check("mis_rsp_error", rsp_error, 1);
        check("mis_htrans", htrans, 2'b00);
        check("mis_hsel", hsel, 0);
        check("mis_cmd_ready", cmd_ready, 1);
        tick();
        check("mis_rsp_single", rsp_valid, 0);
        issue(1'b0, 4'h0, 2'd3, 32'h0);
        tick();
        cmd_valid = 1'b0;
        check("sz3_rsp_error", rsp_error, 1);
        check("sz3_rsp_valid", rsp_valid, 1);
        check("sz3_hsel", hsel, 0);
        issue(1'b0, 4'h5, 2'd1, 32'h0);
        tick();
        cmd_valid = 1'b0;
        check("mis_half_error", rsp_error, 1);
        check("mis_half_htrans", htrans, 2'b00);
        tick();

        // Back-to-back word writes with cmd_valid held high.
        issue(1'b1, 4'h4, 2'd2, 32'h11111111);
        for (int i = 0; i < 3; i++) begin
            a_exp  = 4'(4 * (i + 1));
            wd_exp = 32'h11111111 * (i + 1);
            tick();
            cmd_addr  = 4'(4 * (i + 2));
            cmd_wdata = 32'h11111111 * (i + 2);
            check("b2b_htrans", htrans, 2'b10);
            check("b2b_haddr", haddr, a_exp);
            tick();
            check("b2b_hwdata", hwdata, wd_exp);
            tick();
            check("b2b_rsp_valid", rsp_valid, 1);
            check("b2b_cmd_ready", cmd_ready, 1);
            if (i == 2) cmd_valid = 1'b0;
        end
        tick();
        check("b2b_idle_after", htrans, 2'b00);
        check("b2b_rsp_drop", rsp_valid, 0);

        // Subordinate stalls the data phase indefinitely.
        issue(1'b0, 4'h0, 2'd2, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        hready = 1'b0;
`ifdef AHB_MGR_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            check("tmo_wait", rsp_valid, 0);
        end
        tick();
        check("tmo_rsp_valid", rsp_valid, 1);
        check("tmo_rsp_error", rsp_error, 1);
        check("tmo_rsp_timeout", rsp_timeout, 1);
        check("tmo_hsel", hsel, 0);
        check("tmo_cmd_ready", cmd_ready, 1);
        hready = 1'b1;
        tick();
        check("tmo_rsp_single", rsp_valid, 0);
`else
        for (int i = 0; i < 12; i++) begin
            tick();
            check("stall_no_rsp", rsp_valid, 0);
        end
        check("stall_busy", cmd_ready, 0);
        hready = 1'b1;
        hrdata = 32'hCAFEF00D;
        tick();
        check("stall_rsp_valid", rsp_valid, 1);
        check("stall_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
        check("stall_rsp_timeout", rsp_timeout, 0);
        hrdata = 32'h0;
`endif

        // Reset during a stalled address phase.
        tick();
        hready = 1'b0;
        issue(1'b1, 4'hC, 2'd2, 32'h87654321);
        tick();
        cmd_valid = 1'b0;
        check("rstm_htrans1", htrans, 2'b10);
        tick();
        check("rstm_htrans_stable", htrans, 2'b10);
        check("rstm_haddr", haddr, 4'hC);
        rst = 1'b1;
        tick();
        check("rstm_htrans", htrans, 2'b00);
        check("rstm_hsel", hsel, 0);
        check("rstm_haddr0", haddr, 0);
        check("rstm_hwrite", hwrite, 0);
        check("rstm_cmd_ready", cmd_ready, 1);
        check("rstm_rsp_valid", rsp_valid, 0);
        rst    = 1'b0;
        hready = 1'b1;
        tick();
        check("rstm_no_rsp1", rsp_valid, 0);
        tick();
        check("rstm_no_rsp2", rsp_valid, 0);
        check("rstm_idle", htrans, 2'b00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
